// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: op codes, FSM encodings, default widths.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package shift_seq_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SHW_DEF   = 5;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/shift_seq_shift1_unit.sv
// Single-position shifter stage: acc shifted by one bit according to op (11 acts as SLL).
// Latency: purely combinational.
// Backpressure: none; right shifts exist only when SHIFT_SEQ_RIGHT_EN is defined, else every op is SLL.
module shift1_unit
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] nxt
);

`ifdef SHIFT_SEQ_RIGHT_EN
  // Select the one-bit step; reserved op code falls back to a left shift.
  always_comb begin
    nxt = {acc[WIDTH-2:0], 1'b0};
    case (op)
      OP_SRL:  nxt = {1'b0, acc[WIDTH-1:1]};
      OP_SRA:  nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: nxt = {acc[WIDTH-2:0], 1'b0};
    endcase
  end
`else
  // Right-shift logic is not built; op is kept only so the port list stays stable.
  logic unused_op;
  assign unused_op = ^op;

  // Only the left-shift step exists in this build.
  always_comb begin
    nxt = {acc[WIDTH-2:0], 1'b0};
  end
`endif

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: one command applies shamt single-bit steps, then pulses done with result.
// Latency: shamt+2 cycles from accepted start to done; next command accepted shamt+3 edges after the previous.
// Backpressure: start is taken only in IDLE; strobes during RUN/DONE are dropped (no queueing). SHIFT_SEQ_RIGHT_EN enables SRL/SRA.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] num,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t           state;
  state_t           state_d;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] nxt_acc;
  logic [SHW-1:0]   cnt;
  logic [1:0]       op_q;

  shift1_unit #(
    .WIDTH (WIDTH)
  ) u_shift1 (
    .acc (acc),
    .op  (op_q),
    .nxt (nxt_acc)
  );

  // State register; reset aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state: accept in IDLE, step until the counter drains, one DONE cycle.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (cnt == '0) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: latch the command on acceptance, then one shift step per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      cnt  <= '0;
      op_q <= OP_SLL;
    end else if (state == ST_IDLE && start) begin
      acc  <= num;
      cnt  <= shamt;
      op_q <= op;
    end else if (state == ST_RUN && cnt != '0) begin
      acc <= nxt_acc;
      cnt <= cnt - SHW'(1);
    end
  end

  // Registered outputs: done/result trail the DONE state by one edge, and busy
  // covers that pulse cycle too, so it drops together with done. A start seen
  // on the edge ending the pulse is accepted (state is already IDLE there).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      busy <= (state_d != ST_IDLE) || (state == ST_DONE);
      done <= (state == ST_DONE);
      if (state == ST_DONE) result <= acc;
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed commands, scoreboard of expected results/done cycles.
// Latency: checks done at exactly acceptance edge + shamt + 2, busy every cycle.
// Backpressure: checks that strobes while busy are dropped and reset aborts without a done.
module tb_shift_seq;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] num = '0;
  logic [4:0]  shamt = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  exp_t sb[$];

  shift_seq #(
    .WIDTH (32),
    .SHW   (5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .num    (num),
    .shamt  (shamt),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: busy against the window model, done against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_busy;
      exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      tests++;
      if (busy !== exp_busy) begin
        fails++;
        $display("FAIL busy@cyc%0d: got %b want %b", cyc, busy, exp_busy);
      end
      if (sb.size() != 0 && cyc > sb[0].due) begin
        exp_t m;
        m = sb.pop_front();
        tests++;
        fails++;
        $display("FAIL %s: no done by cyc %0d (due %0d)", m.name, cyc, m.due);
      end
      if (done === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done@cyc%0d: got done=1 want 0", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (cyc != e.due) begin
            fails++;
            $display("FAIL %s_latency: done at cyc %0d want %0d", e.name, cyc, e.due);
          end
          tests++;
          if (result !== e.res) begin
            fails++;
            $display("FAIL %s_result: got %h want %h", e.name, result, e.res);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Issue a command; returns the acceptance edge count.
  task automatic issue(input string name, input logic [1:0] o, input logic [31:0] n,
                       input logic [4:0] s, input logic [31:0] want, output int e);
    exp_t x;
    @(negedge clk);
    op = o;
    num = n;
    shamt = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    start = 1'b0;
    x.res = want;
    x.due = e + int'(s) + 2;
    x.name = name;
    sb.push_back(x);
    busy_lo = e;
    busy_hi = e + int'(s) + 2;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: pending=%0d busy=%b want idle", name, sb.size(), busy);
      sb.delete();
    end
  endtask

  initial begin
    int e;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    issue("sll4", 2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010, e);
    wait_idle("sll4");
    // Inputs changing after acceptance must not matter.
    issue("sh0", 2'b00, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, e);
    num = 32'h1234_5678;
    shamt = 5'd9;
    wait_idle("sh0");
    issue("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, e);
    wait_idle("sll31");
`ifdef SHIFT_SEQ_RIGHT_EN
    issue("sra31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, e);
    wait_idle("sra31");
    issue("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, e);
    wait_idle("srl31");
    issue("sra1", 2'b10, 32'h0000_0003, 5'd1, 32'h0000_0001, e);
    wait_idle("sra1");
    issue("rsv2", 2'b11, 32'h0000_0003, 5'd2, 32'h0000_000C, e);
    wait_idle("rsv2");
`else
    issue("op10_sll", 2'b10, 32'h0000_0003, 5'd1, 32'h0000_0006, e);
    wait_idle("op10_sll");
    issue("op01_sll", 2'b01, 32'h8000_0001, 5'd3, 32'h0000_0008, e);
    wait_idle("op01_sll");
`endif

    // Extra strobes during RUN and on the DONE-state edge are dropped.
    issue("strobes", 2'b00, 32'h0000_00F0, 5'd6, 32'h0000_3C00, e);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (((cyc - e) % 2) == 1) begin
        num = $urandom;
        shamt = 5'(k + 2);
        op = 2'b01;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle("strobes");

    // Asynchronous reset mid-RUN aborts with no done.
    issue("abort", 2'b00, 32'h0000_0001, 5'd20, 32'h0010_0000, e);
    repeat (5) @(negedge clk);
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    sb.delete();
    busy_lo = 1;
    busy_hi = 0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("after_abort_result", result, 32'd0);

    issue("post_abort", 2'b00, 32'h0000_00A5, 5'd3, 32'h0000_0528, e);
    wait_idle("post_abort");
    check("result_hold", result, 32'h0000_0528);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
